// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the multi-channel BRAM arbiter and any other
// block that arbitrates a shared resource among up to MAX_CH requesters.
package bram_arb_pkg;

    localparam int MAX_CH   = 8;
    localparam int CH_IDX_W = $clog2(MAX_CH);

    typedef logic [MAX_CH-1:0]   ch_oh_t;
    typedef logic [CH_IDX_W-1:0] ch_idx_t;

    // Travels alongside each issued read until its data leaves the BRAM.
    typedef struct packed {
        logic   valid;
        ch_oh_t ch_oh;
    } rd_tag_t;

    function automatic ch_idx_t oh2idx(input ch_oh_t oh);
        ch_idx_t idx;
        idx = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (oh[i]) begin
                idx = ch_idx_t'(i);
            end
        end
        return idx;
    endfunction

    function automatic ch_oh_t idx2oh(input ch_idx_t idx);
        ch_oh_t oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: the first requester at or above ptr wins,
// otherwise the first requester below ptr. At most one grant bit is set.
module rr_arbiter
    import bram_arb_pkg::*;
#(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic found;

    // Two ascending passes realise the modulo-N search starting at ptr.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i < int'(ptr))) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        grant_idx = IDX_W'(oh2idx(ch_oh_t'(grant)));
    end

endmodule

// File: rtl/bram_mc_arbiter.sv
// N-channel front end to a single-port BRAM: round-robin grant, one
// registered access per cycle, and a tag pipeline that routes read data
// back to the requesting channel after the BRAM latency.
module bram_mc_arbiter
    import bram_arb_pkg::*;
#(
    parameter  int N_CH   = 4,
    parameter  int ADDR_W = 10,
    parameter  int DATA_W = 1408,
    parameter  int RD_LAT = 1,
    localparam int IDX_W  = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH-1:0]          req_valid,
    output logic [N_CH-1:0]          req_ready,
    input  logic [N_CH-1:0]          req_we,
    input  logic [N_CH*ADDR_W-1:0]   req_addr,
    input  logic [N_CH*DATA_W-1:0]   req_data,
    output logic [N_CH-1:0]          rsp_valid,
    output logic [DATA_W-1:0]        rsp_data,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic [DATA_W-1:0]        ram_data,
    output logic                     ram_we,
    output logic                     ram_re,
    input  logic [DATA_W-1:0]        ram_q
);

    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  grant_idx;
    logic [N_CH-1:0]   grant;
    logic              accept;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [N_CH-1:0]   issue_oh;
    rd_tag_t           tag_pipe [RD_LAT];

    rr_arbiter #(.N(N_CH)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // No channel may see a handshake while the block is held in reset.
    assign req_ready = rst_n ? grant : '0;
    assign accept    = |req_ready;

    // Select the winning channel's request fields (grant is one-hot).
    always_comb begin
        sel_we   = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) begin
                sel_we   = req_we[i];
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Advance the round-robin pointer past the channel just served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (grant_idx == IDX_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Issue stage; address and data hold when idle to avoid needless toggling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr <= '0;
            ram_data <= '0;
            ram_we   <= 1'b0;
            ram_re   <= 1'b0;
            issue_oh <= '0;
        end else begin
            ram_we   <= accept & sel_we;
            ram_re   <= accept & ~sel_we;
            issue_oh <= grant;
            if (accept) begin
                ram_addr <= sel_addr;
                ram_data <= sel_data;
            end
        end
    end

    // Tag pipeline: follows each read through the BRAM so the response is tagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= '{valid: ram_re, ch_oh: ch_oh_t'(issue_oh)};
            for (int i = 1; i < RD_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign rsp_valid = tag_pipe[RD_LAT-1].valid ? N_CH'(tag_pipe[RD_LAT-1].ch_oh) : '0;
    assign rsp_data  = ram_q;

endmodule

// File: tb/tb_bram_mc_arbiter.sv
// Self-checking bench for bram_mc_arbiter (N_CH=4, RD_LAT=2). A BRAM model
// preloaded with mem[a]=a*3 sits behind the DUT; a transaction-level
// reference (pending-request table, pointer, memory image, response queue)
// predicts every output cycle by cycle.
module tb_bram_mc_arbiter;

    localparam int N_CH   = 4;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N_CH-1:0]        req_valid;
    logic [N_CH-1:0]        req_ready;
    logic [N_CH-1:0]        req_we;
    logic [N_CH*ADDR_W-1:0] req_addr;
    logic [N_CH*DATA_W-1:0] req_data;
    logic [N_CH-1:0]        rsp_valid;
    logic [DATA_W-1:0]      rsp_data;
    logic [ADDR_W-1:0]      ram_addr;
    logic [DATA_W-1:0]      ram_data;
    logic                   ram_we;
    logic                   ram_re;
    logic [DATA_W-1:0]      ram_q;

    bram_mc_arbiter #(
        .N_CH   (N_CH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .ram_we    (ram_we),
        .ram_re    (ram_re),
        .ram_q     (ram_q)
    );

    always #5 clk = ~clk;

    // BRAM model: two-cycle read latency, read-before-write in the same cycle.
    logic [DATA_W-1:0] bram [DEPTH];
    logic [DATA_W-1:0] rd_stage;

    always @(posedge clk) begin
        if (ram_re) rd_stage <= bram[ram_addr];
        ram_q <= rd_stage;
        if (ram_we) bram[ram_addr] = ram_data;
    end

    // Reference model state
    typedef struct {
        int              due;
        logic [N_CH-1:0] oh;
        logic [DATA_W-1:0] data;
    } rsp_t;

    rsp_t              exp_q [$];
    logic [DATA_W-1:0] ref_mem [DEPTH];
    int                m_ptr;
    logic              iss_we, iss_re;
    logic [ADDR_W-1:0] iss_addr;
    logic [DATA_W-1:0] iss_data;
    logic [N_CH-1:0]   pend_valid, pend_we;
    logic [ADDR_W-1:0] pend_addr [N_CH];
    logic [DATA_W-1:0] pend_data [N_CH];
    int                cycle;
    int                total = 0;
    int                bad   = 0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < N_CH; i++) begin
            req_valid[i]                  = pend_valid[i];
            req_we[i]                     = pend_we[i];
            req_addr[i*ADDR_W +: ADDR_W]  = pend_addr[i];
            req_data[i*DATA_W +: DATA_W]  = pend_data[i];
        end
    endtask

    task automatic setReq(input int ch, input logic we, input int addr, input logic [DATA_W-1:0] data);
        pend_valid[ch] = 1'b1;
        pend_we[ch]    = we;
        pend_addr[ch]  = ADDR_W'(addr);
        pend_data[ch]  = data;
    endtask

    task automatic resetModel();
        m_ptr    = 0;
        iss_we   = 1'b0;
        iss_re   = 1'b0;
        iss_addr = '0;
        iss_data = '0;
        exp_q.delete();
    endtask

    // One clock: drive, check at negedge against the model, then commit the model at posedge.
    task automatic stepCycle();
        int              w;
        logic [N_CH-1:0] exp_ready;
        rsp_t            head;
        applyStimulus();
        @(negedge clk);
        w = -1;
        for (int k = 0; k < N_CH; k++) begin
            int c;
            c = (m_ptr + k) % N_CH;
            if (w < 0 && pend_valid[c]) w = c;
        end
        exp_ready = (w >= 0) ? N_CH'(1 << w) : '0;
        checkOutput("req_ready", 64'(req_ready), 64'(exp_ready));
        checkOutput("ram_we",    64'(ram_we),    64'(iss_we));
        checkOutput("ram_re",    64'(ram_re),    64'(iss_re));
        checkOutput("ram_addr",  64'(ram_addr),  64'(iss_addr));
        checkOutput("ram_data",  64'(ram_data),  64'(iss_data));
        if (exp_q.size() > 0 && exp_q[0].due == cycle) begin
            head = exp_q.pop_front();
            checkOutput("rsp_valid", 64'(rsp_valid), 64'(head.oh));
            checkOutput("rsp_data",  64'(rsp_data),  64'(head.data));
        end else begin
            checkOutput("rsp_valid_idle", 64'(rsp_valid), 64'(0));
        end
        @(posedge clk);
        cycle++;
        if (w >= 0) begin
            iss_we   = pend_we[w];
            iss_re   = !pend_we[w];
            iss_addr = pend_addr[w];
            iss_data = pend_data[w];
            if (pend_we[w]) begin
                ref_mem[pend_addr[w]] = pend_data[w];
            end else begin
                exp_q.push_back('{due: cycle + RD_LAT, oh: N_CH'(1 << w), data: ref_mem[pend_addr[w]]});
            end
            pend_valid[w] = 1'b0;
            m_ptr         = (w + 1) % N_CH;
        end else begin
            iss_we = 1'b0;
            iss_re = 1'b0;
        end
        #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        @(negedge clk);
        checkOutput({tag, "_ready"},  64'(req_ready), 64'(0));
        checkOutput({tag, "_we"},     64'(ram_we),    64'(0));
        checkOutput({tag, "_re"},     64'(ram_re),    64'(0));
        checkOutput({tag, "_rsp"},    64'(rsp_valid), 64'(0));
        checkOutput({tag, "_addr"},   64'(ram_addr),  64'(0));
    endtask

    initial begin
        for (int a = 0; a < DEPTH; a++) begin
            bram[a]    = DATA_W'(a * 3);
            ref_mem[a] = DATA_W'(a * 3);
        end
        cycle      = 0;
        pend_valid = '0;
        pend_we    = '0;
        for (int i = 0; i < N_CH; i++) begin
            pend_addr[i] = '0;
            pend_data[i] = '0;
        end
        resetModel();

        // Reset with every channel requesting: nothing may be granted.
        rst_n = 1'b0;
        for (int i = 0; i < N_CH; i++) setReq(i, 1'b0, i, '0);
        applyStimulus();
        repeat (2) checkResetOutputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        resetModel();
        repeat (8) stepCycle();

        // Full contention: every channel keeps reading addr i+10.
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < N_CH; i++) begin
                if (!pend_valid[i]) setReq(i, 1'b0, i + 10, '0);
            end
            stepCycle();
        end
        pend_valid = '0;
        repeat (5) stepCycle();

        // Single read from ch2 at address 5.
        setReq(2, 1'b0, 5, '0);
        repeat (5) stepCycle();

        // Write then read of the same address from different channels.
        setReq(1, 1'b1, 7, 32'hABC);
        stepCycle();
        setReq(3, 1'b0, 7, '0);
        repeat (5) stepCycle();

        // Pointer wrap: leave the pointer at 1, then contend ch0 against ch3.
        setReq(0, 1'b0, 1, '0);
        stepCycle();
        setReq(0, 1'b0, 2, '0);
        setReq(3, 1'b0, 3, '0);
        repeat (5) stepCycle();

        // Reset while two reads are in flight: their responses must vanish.
        setReq(0, 1'b0, 20, '0);
        setReq(1, 1'b0, 21, '0);
        repeat (3) stepCycle();
        rst_n = 1'b0;
        repeat (2) checkResetOutputs("inflight");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        resetModel();
        repeat (6) stepCycle();

        // Random traffic on a small address range to exercise read-after-write.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N_CH; i++) begin
                if (!pend_valid[i] && $urandom_range(0, 1) == 1) begin
                    setReq(i, ($urandom_range(0, 2) == 0), int'($urandom_range(0, 15)), DATA_W'($urandom));
                end
            end
            stepCycle();
        end
        pend_valid = '0;
        repeat (6) stepCycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bram_mc_arbiter.md
Name: bram_mc_arbiter

Overview:
N-channel front end to one single-port block RAM, with round-robin arbitration.
- Each channel issues reads and writes over a valid/ready request handshake.
- Read data returns on a shared response bus, tagged with a one-hot channel vector.
- Generalises the single-master BRAM port to N masters, with configurable BRAM read latency.
- Sits between the NPU engines (weight fetch, activation load/store, DMA) and a shared on-chip buffer.

Parameters:
N_CH, 4, number of requesting channels (2..8)
ADDR_W, 10, BRAM word-address width
DATA_W, 1408, BRAM word width in bits (176*8)
RD_LAT, 1, BRAM read latency in cycles, from sampled ram_re to valid ram_q (1..4)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  N_CH  per-channel request valid
req_ready  out  N_CH  per-channel request accepted this cycle
req_we  in  N_CH  per-channel 1=write, 0=read
req_addr  in  N_CH*ADDR_W  per-channel address, channel i at [i*ADDR_W +: ADDR_W]
req_data  in  N_CH*DATA_W  per-channel write data, channel i at [i*DATA_W +: DATA_W]
rsp_valid  out  N_CH  one-hot read-response valid
rsp_data  out  DATA_W  read data, shared by all channels
ram_addr  out  ADDR_W  BRAM address
ram_data  out  DATA_W  BRAM write data
ram_we  out  1  BRAM write enable
ram_re  out  1  BRAM read enable
ram_q  in  DATA_W  BRAM read data

Behaviour:
- Reset (async assert, sync release)
  - ram_addr, ram_data, ram_we, ram_re = 0
  - rr_ptr = 0; tag pipeline cleared; rsp_valid = 0
  - req_ready is combinational, so it is 0 while in reset.
- Arbitration
  - Combinational, at most one grant per cycle.
  - Search starts at rr_ptr, ascending modulo N_CH; the first channel with req_valid=1 wins.
  - req_ready[g] = 1 for the winner only. It never asserts for a channel whose req_valid=0.
- Acceptance and pointer
  - Acceptance occurs when req_valid & req_ready on a clock edge.
  - On acceptance of channel g: rr_ptr <= (g+1) mod N_CH, wrapping at N_CH-1 -> 0.
  - With no valid request, rr_ptr holds.
- Requester rules
  - Once req_valid is asserted, req_we, req_addr and req_data stay stable until accepted.
  - req_valid must not be withdrawn before acceptance.
- Issue (registered, 1 cycle)
  - Request accepted at edge T drives ram_addr/ram_data/ram_we/ram_re during cycle T+1.
  - ram_we = req_we; ram_re = !req_we. They are never both 1.
- Idle cycles
  - ram_we = ram_re = 0.
  - ram_addr/ram_data hold their last values, to save toggle power.
- Read tagging
  - A shift register of depth RD_LAT carries {valid, one-hot channel} alongside each issued read.
  - rsp_valid = tag output, asserted in cycle T+1+RD_LAT. Total read latency from acceptance = 1+RD_LAT.
  - rsp_data = ram_q, combinational pass-through; meaningful only while |rsp_valid.
- Writes produce no response.
- Throughput and ordering
  - One access per cycle; back-to-back reads are fully pipelined.
  - Accesses execute in acceptance order; read-after-write ordering follows BRAM write-first or read-first semantics.
- No response back-pressure: each channel must sink rsp_valid in the cycle it is asserted.
- Reset mid-operation: in-flight reads are discarded, and no rsp_valid asserts after release for pre-reset requests.
- Starvation bound: a continuously valid channel is granted within N_CH cycles.

Decomposition:
- Package bram_arb_pkg holds:
  - localparam MAX_CH = 8
  - typedef ch_oh_t (logic [N_CH-1:0] style one-hot, sized by a package parameter)
  - function oh2idx / idx2oh
  - typedef struct rd_tag_t {valid, ch_oh}
- One sub-module: rr_arbiter (N-way round-robin, inputs req and ptr, outputs one-hot grant and grant index). It is reusable by other shared-resource blocks.
- Top level holds the request mux, issue registers and tag pipeline.

Test Plan:
All scenarios use N_CH=4, RD_LAT=2, and a BRAM model preloaded with mem[a]=a*3.
1. Reset check: hold rst_n=0 with all req_valid=1 -> req_ready=0, ram_we=ram_re=0, rsp_valid=0, ram_addr=0. Deassert rst_n -> first grant goes to ch0.
2. Single read: ch2 reads addr 0x05, accepted at edge T.
   - Cycle T+1: ram_re=1, ram_addr=5.
   - Cycle T+3: rsp_valid=4'b0100, rsp_data=15.
3. Full contention: all four channels read continuously, ch i at addr i+10.
   - Grants go 0,1,2,3,0 on consecutive cycles.
   - rsp_valid sequence 0001,0010,0100,1000 starts 3 cycles after the first acceptance, with rsp_data 30,33,36,39.
4. Write then read: ch1 writes addr 7 data 0xABC; ch3 reads addr 7 on the next cycle -> ram_we precedes ram_re, and ch3 receives rsp_data=0xABC.
5. Pointer wrap: rr_ptr=1, ch0 and ch3 valid -> ch3 granted first (ptr becomes 0), then ch0 (ptr becomes 1).
6. Reset in flight: accept two reads, assert rst_n=0 one cycle later for 2 cycles -> rsp_valid stays 0 through and after release.
